// File: rtl/edge_pulse_gen.sv
// Multi-channel edge one-shot: per-channel synchroniser, debounce filter and
// fixed-length pulse on a selectable edge, plus a registered OR of all pulses.
module edge_pulse_gen #(
  parameter int unsigned N           = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DEB_CYCLES  = 4,
  parameter int unsigned PULSE_LEN   = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] din,
  input  logic [1:0]   mode,
  input  logic         en,
  output logic [N-1:0] level,
  output logic [N-1:0] pulse,
  output logic         any_pulse
);

  localparam int unsigned CW = $clog2(DEB_CYCLES + 1);
  localparam int unsigned PW = $clog2(PULSE_LEN + 1);

  localparam logic [CW-1:0] CNT_LAST  = CW'(DEB_CYCLES - 1);
  localparam logic [PW-1:0] PCNT_LOAD = PW'(PULSE_LEN - 1);

  localparam logic [1:0] MODE_RISE = 2'b00;
  localparam logic [1:0] MODE_FALL = 2'b01;
  localparam logic [1:0] MODE_BOTH = 2'b10;

  logic [SYNC_STAGES-1:0] r_sync [N];
  logic [CW-1:0]          r_cnt  [N];
  logic [PW-1:0]          r_pcnt [N];
  logic [N-1:0]           r_level;
  logic [N-1:0]           r_pulse;
  logic                   r_any_pulse;

  logic [N-1:0] w_sync_out;
  logic [N-1:0] w_evt;
  logic [N-1:0] w_qual;
  logic [N-1:0] w_pulse_nxt;
  logic         w_rise_ok;
  logic         w_fall_ok;

  // Edge qualification shared by all channels; mode 11 enables neither edge.
  assign w_rise_ok = en && ((mode == MODE_RISE) || (mode == MODE_BOTH));
  assign w_fall_ok = en && ((mode == MODE_FALL) || (mode == MODE_BOTH));

  // An event fires on the edge where the mismatch has lasted DEB_CYCLES cycles.
  always_comb begin
    w_sync_out  = '0;
    w_evt       = '0;
    w_qual      = '0;
    w_pulse_nxt = '0;
    for (int i = 0; i < int'(N); i++) begin
      w_sync_out[i]  = r_sync[i][SYNC_STAGES-1];
      w_evt[i]       = (w_sync_out[i] != r_level[i]) && (r_cnt[i] == CNT_LAST);
      w_qual[i]      = w_evt[i] && (w_sync_out[i] ? w_rise_ok : w_fall_ok);
      w_pulse_nxt[i] = w_qual[i] || (r_pcnt[i] != '0);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(N); i++) begin
        r_sync[i] <= '0;
        r_cnt[i]  <= '0;
        r_pcnt[i] <= '0;
      end
      r_level     <= '0;
      r_pulse     <= '0;
      r_any_pulse <= 1'b0;
    end else begin
      for (int i = 0; i < int'(N); i++) begin
        r_sync[i][0] <= din[i];
        for (int k = 1; k < int'(SYNC_STAGES); k++) begin
          r_sync[i][k] <= r_sync[i][k-1];
        end

        if ((w_sync_out[i] == r_level[i]) || w_evt[i]) begin
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CW'(1);
        end

        if (w_evt[i]) begin
          r_level[i] <= w_sync_out[i];
        end

        // A qualifying event while active reloads the full pulse length.
        if (w_qual[i]) begin
          r_pcnt[i] <= PCNT_LOAD;
        end else if (r_pcnt[i] != '0) begin
          r_pcnt[i] <= r_pcnt[i] - PW'(1);
        end
      end
      r_pulse     <= w_pulse_nxt;
      r_any_pulse <= |w_pulse_nxt;
    end
  end

  assign level     = r_level;
  assign pulse     = r_pulse;
  assign any_pulse = r_any_pulse;

endmodule

// File: tb/tb_edge_pulse_gen.sv
// Scoreboard bench for edge_pulse_gen: stimulus queues expected pulse cycles,
// per-instance monitors pop and compare whenever a pulse is presented.
module tb_edge_pulse_gen;

  typedef struct {
    int         cyc;
    logic [3:0] pulse;
    logic [3:0] level;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] din;
  logic [3:0] din3;
  logic [1:0] mode;
  logic       en;
  logic [3:0] level, pulse, level3, pulse3;
  logic       any_pulse, any3;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  edge_pulse_gen dut (
    .clk(clk), .reset(reset), .din(din), .mode(mode), .en(en),
    .level(level), .pulse(pulse), .any_pulse(any_pulse)
  );

  edge_pulse_gen #(.N(4), .SYNC_STAGES(2), .DEB_CYCLES(1), .PULSE_LEN(3)) dut3 (
    .clk(clk), .reset(reset), .din(din3), .mode(mode), .en(en),
    .level(level3), .pulse(pulse3), .any_pulse(any3)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push0(input int c, input logic [3:0] p, input logic [3:0] l);
    exp_t e;
    e.cyc = c; e.pulse = p; e.level = l;
    q0.push_back(e);
  endtask

  task automatic push1(input int c, input logic [3:0] p, input logic [3:0] l);
    exp_t e;
    e.cyc = c; e.pulse = p; e.level = l;
    q1.push_back(e);
  endtask

  // Monitor for the default instance
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      chk("any_pulse", int'(any_pulse), int'(|pulse));
      if (pulse != 4'b0000) begin
        if (q0.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse at cycle %0d: got %b expected none", cyc, pulse);
        end else begin
          e0 = q0.pop_front();
          chk("pulse_cycle", cyc, e0.cyc);
          chk("pulse_vec", int'(pulse), int'(e0.pulse));
          chk("pulse_level", int'(level), int'(e0.level));
        end
      end
    end
  end

  // Monitor for the long-pulse, unfiltered instance
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      chk("any_pulse3", int'(any3), int'(|pulse3));
      if (pulse3 != 4'b0000) begin
        if (q1.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse3 at cycle %0d: got %b expected none", cyc, pulse3);
        end else begin
          e1 = q1.pop_front();
          chk("pulse3_cycle", cyc, e1.cyc);
          chk("pulse3_vec", int'(pulse3), int'(e1.pulse));
          chk("pulse3_level", int'(level3), int'(e1.level));
        end
      end
    end
  end

  initial begin
    int c;
    reset = 1'b0;
    din   = 4'b0000;
    din3  = 4'b0000;
    mode  = 2'b00;
    en    = 1'b1;
    #3;
    chk("reset_level", int'(level), 0);
    chk("reset_pulse", int'(pulse), 0);
    chk("reset_any", int'(any_pulse), 0);
    tick(2);
    reset = 1'b1;
    tick(3);

    // Single rise on channel 0
    c = cyc; din = 4'b0001; push0(c + 6, 4'b0001, 4'b0001);
    tick(10);
    chk("t1_level", int'(level), 1);

    // Glitches of 2 and 3 cycles are rejected; 4 cycles is accepted
    din = 4'b0011; tick(2); din = 4'b0001; tick(8);
    chk("glitch2_level", int'(level), 1);
    din = 4'b0011; tick(3); din = 4'b0001; tick(8);
    chk("glitch3_level", int'(level), 1);
    c = cyc; din = 4'b0011; push0(c + 6, 4'b0010, 4'b0011);
    tick(4); din = 4'b0001; tick(10);
    chk("min_width_level", int'(level), 1);

    // Fall mode, then both edges on channel 2
    mode = 2'b01;
    din = 4'b0101; tick(10);
    chk("fallmode_rise_level", int'(level), 5);
    c = cyc; din = 4'b0001; push0(c + 6, 4'b0100, 4'b0001); tick(10);
    mode = 2'b10;
    c = cyc; din = 4'b0101; push0(c + 6, 4'b0100, 4'b0101); tick(10);
    c = cyc; din = 4'b0001; push0(c + 6, 4'b0100, 4'b0001); tick(10);

    // Enable low: level follows, no pulse; en dropped only on the event edge
    mode = 2'b00; en = 1'b0;
    din = 4'b1001; tick(10);
    chk("en0_level", int'(level), 9);
    en = 1'b1; mode = 2'b01;
    c = cyc; din = 4'b0001; tick(5); en = 1'b0; tick(1); en = 1'b1; tick(8);
    chk("en_edge_level", int'(level), 1);

    // Mode 11 disables all edges
    mode = 2'b11;
    din = 4'b0101; tick(10);
    chk("mode11_rise_level", int'(level), 5);
    din = 4'b0001; tick(10);
    chk("mode11_fall_level", int'(level), 1);

    // All channels rising together
    mode = 2'b00;
    din = 4'b0000; tick(10);
    c = cyc; din = 4'b1111; push0(c + 6, 4'b1111, 4'b1111); tick(10);
    din = 4'b0000; tick(10);

    // Reset while a pulse is high, then recovery with din[3] held
    c = cyc; din = 4'b1000; tick(6);
    chk("prereset_pulse", int'(pulse), 8);
    chk("prereset_any", int'(any_pulse), 1);
    reset = 1'b0; #1;
    chk("midreset_pulse", int'(pulse), 0);
    chk("midreset_level", int'(level), 0);
    chk("midreset_any", int'(any_pulse), 0);
    tick(2);
    c = cyc; reset = 1'b1; push0(c + 6, 4'b1000, 4'b1000);
    tick(10);

    // PULSE_LEN=3 retrigger two cycles into the pulse -> 5 cycles high
    mode = 2'b10;
    c = cyc; din3 = 4'b0001;
    push1(c + 3, 4'b0001, 4'b0001);
    push1(c + 4, 4'b0001, 4'b0001);
    push1(c + 5, 4'b0001, 4'b0000);
    push1(c + 6, 4'b0001, 4'b0000);
    push1(c + 7, 4'b0001, 4'b0000);
    tick(2); din3 = 4'b0000; tick(10);

    // Mode change mid-pulse does not shorten it; held input gives no repeat
    mode = 2'b00;
    c = cyc; din3 = 4'b0010;
    push1(c + 3, 4'b0010, 4'b0010);
    push1(c + 4, 4'b0010, 4'b0010);
    push1(c + 5, 4'b0010, 4'b0010);
    tick(3); mode = 2'b11; tick(10);
    mode = 2'b00; tick(5);

    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
